dl11_serial_core: RTL and testbench
===================================

Name: dl11_serial_core

Overview:
- Console serial engine behind the DL11 register block.
- Contains a baud-rate generator and an 8N1 UART transmitter and receiver.
- The register layer loads transmit bytes through a four-phase req/ack handshake and unloads received bytes the same way.
- All logic runs on one system clock; baud timing comes from clock-enable ticks, not derived clocks.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits per second.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- ld_tx_req  in  1  request to load tx_data into the transmitter.
- ld_tx_ack  out  1  transmit load acknowledge.
- tx_data  in  8  byte to transmit.
- tx_enable  in  1  permits the start of new transmit frames.
- tx_out  out  1  serial line output; idles high.
- tx_empty  out  1  1 = no byte pending or shifting.
- uld_rx_req  in  1  request to unload the received byte.
- uld_rx_ack  out  1  receive unload acknowledge.
- rx_data  out  8  last received byte.
- rx_enable  in  1  permits reception.
- rx_in  in  1  serial line input; asynchronous to clk.
- rx_empty  out  1  1 = no unread byte.

Behaviour:
- Reset values: tx_out=1, tx_empty=1, ld_tx_ack=0, rx_empty=1, uld_rx_ack=0, rx_data=0. All counters are cleared.
- Reset is honoured mid-frame: the frame is abandoned immediately.
- Baud generator:
  - rx_tick pulses for one clk every RX_DIV=CLK_HZ/(16*BAUD) cycles (integer division, minimum 1).
  - tx_tick pulses once every 16 rx_ticks, so both ticks stay phase-locked.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- TX load handshake:
  - When ld_tx_req=1 and tx_empty=1, the block latches tx_data on that edge, clears tx_empty and sets ld_tx_ack on the same edge.
  - If tx_empty=0, ack is withheld until tx_empty returns to 1.
  - ld_tx_ack stays 1 while req=1 and clears on the first edge after req is seen low.
  - Only one load per req pulse.
- TX engine:
  - At the next tx_tick with a byte pending and tx_enable=1, the start bit is driven. Each subsequent tx_tick advances one bit.
  - tx_empty returns to 1 on the tx_tick that ends the stop bit.
  - tx_enable=0 blocks starting a frame but never truncates one in progress.
- TX states: IDLE, START, DATA (3-bit index 0..7), STOP.
- RX front end:
  - rx_in passes through a 2-flop synchronizer.
  - While rx_enable=0 the receiver is held in IDLE and any partial frame is discarded.
- RX engine, counted in rx_ticks:
  - A low level in IDLE starts a 16x sample count.
  - At count 8 the line is re-checked. If it is high, the event is a glitch and the receiver returns to IDLE.
  - Each data bit and the stop bit are sampled at their mid-point, every 16 ticks.
- RX states: IDLE, START, DATA, STOP.
- RX completion, stop bit = 1: rx_data is updated and rx_empty=0 on the same edge.
- Overrun: if rx_empty was already 0, the new byte overwrites rx_data.
- Frame error, stop bit = 0: the byte is discarded and rx_data and rx_empty are unchanged. The receiver waits for the line to go high before re-arming.
- RX unload handshake:
  - uld_rx_req=1 sets uld_rx_ack and sets rx_empty=1 on the same edge.
  - ack clears on the first edge after req is low.
  - rx_data is NOT cleared by unload; it holds until the next good frame.
- Simultaneous unload and frame completion: the completion wins. rx_empty ends at 0 with the new data.

Optional Feature:
- Macro: UART_ERR_FLAGS_EN.
- When defined, two extra outputs are added: rx_frame_err and rx_overrun, each 1 bit, reset 0.
  - rx_frame_err is set on a bad stop bit.
  - rx_overrun is set when a good byte arrives while rx_empty=0.
  - Both flags clear on a uld_rx_req handshake. A new set event on that same edge wins.
- When not defined, neither port exists; errors are silently handled as above.

Decomposition:
- Shared package dl11_serial_pkg holds:
  - TX and RX state enum typedefs;
  - constants OVERSAMPLE=16, DATA_BITS=8, MID_SAMPLE=8.
- One sub-module, dl11_baud_gen (params CLK_HZ, BAUD; outputs rx_tick, tx_tick).
- TX and RX stay inline.

Test Plan (CLK_HZ=160000, BAUD=10000, giving RX_DIV=1 and 16 clks per bit):
- Reset: with reset low, check tx_out=1, tx_empty=1, rx_empty=1, rx_data=8'h00, both acks 0.
- TX: pulse ld_tx_req with tx_data=8'h41.
  - ld_tx_ack rises 1 clk after req and falls 1 clk after req falls.
  - tx_out shows 0,1,0,0,0,0,0,1,0,1 at 16-clk bits.
  - tx_empty returns to 1 after the stop bit.
- TX backpressure: issue a second req while the first byte is shifting; ack is delayed until tx_empty=1, then the second byte follows back-to-back.
- RX: drive 8'h0D as 8N1 on rx_in.
  - rx_empty falls with rx_data=8'h0D.
  - uld_rx_req gives ack, rx_empty=1, and rx_data still 8'h0D.
- RX frame error: drive 8'h55 with stop=0; rx_empty stays 1 (rx_frame_err=1 with UART_ERR_FLAGS_EN).
- RX glitch and disable:
  - A 4-clk low pulse on rx_in yields no byte.
  - With rx_enable=0, a valid frame of 8'hAA yields no byte.

Source files
------------

// File: rtl/dl11_serial_pkg.sv
// Shared types and constants for the DL11 console serial engine.
// Optional build macro: UART_ERR_FLAGS_EN (adds rx_frame_err / rx_overrun outputs).
package dl11_serial_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int DATA_BITS  = 8;
   localparam int MID_SAMPLE = 8;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/dl11_serial_core_baud_gen.sv
// Baud-rate generator: 16x oversample enable (rx_tick) and a phase-locked bit enable (tx_tick).
// Module name dl11_baud_gen; no build macros.
module dl11_baud_gen
   import dl11_serial_pkg::*;
#(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 9600
) (
   input  logic clk,
   input  logic reset,
   output logic rx_tick,
   output logic tx_tick
);

   localparam int RAW_DIV = CLK_HZ / (OVERSAMPLE * BAUD);
   localparam int RX_DIV  = (RAW_DIV < 1) ? 1 : RAW_DIV;
   localparam int CW      = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(RX_DIV - 1);

   logic [CW-1:0] div_cnt;
   logic [3:0]    sub_cnt;

   assign rx_tick = (div_cnt == DIV_LAST);
   // tx_tick is derived from the rx_tick count so the two never drift apart.
   assign tx_tick = rx_tick && (sub_cnt == 4'(OVERSAMPLE - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
         sub_cnt <= '0;
      end else if (rx_tick) begin
         div_cnt <= '0;
         sub_cnt <= sub_cnt + 4'd1;
      end else begin
         div_cnt <= div_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/dl11_serial_core.sv
// DL11 console serial engine: 8N1 UART transmitter/receiver with req/ack load/unload handshakes.
// Optional build macro UART_ERR_FLAGS_EN adds rx_frame_err and rx_overrun sticky flags.
module dl11_serial_core
   import dl11_serial_pkg::*;
#(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 9600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ld_tx_req,
   output logic       ld_tx_ack,
   input  logic [7:0] tx_data,
   input  logic       tx_enable,
   output logic       tx_out,
   output logic       tx_empty,
   input  logic       uld_rx_req,
   output logic       uld_rx_ack,
   output logic [7:0] rx_data,
   input  logic       rx_enable,
   input  logic       rx_in,
   output logic       rx_empty
`ifdef UART_ERR_FLAGS_EN
   ,
   output logic       rx_frame_err,
   output logic       rx_overrun
`endif
);

   logic rx_tick;
   logic tx_tick;

   dl11_baud_gen #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_baud (
      .clk     (clk),
      .reset   (reset),
      .rx_tick (rx_tick),
      .tx_tick (tx_tick)
   );

   tx_state_t  tx_state, tx_state_nxt;
   logic [2:0] tx_idx;
   logic [7:0] tx_shift;
   logic       tx_load;
   logic       tx_done;

   always_comb begin
      tx_state_nxt = tx_state;
      tx_load      = ld_tx_req && !ld_tx_ack && tx_empty;
      tx_done      = 1'b0;
      if (tx_tick) begin
         case (tx_state)
            TX_IDLE:  if (!tx_empty && tx_enable) tx_state_nxt = TX_START;
            TX_START: tx_state_nxt = TX_DATA;
            TX_DATA:  if (tx_idx == 3'(DATA_BITS - 1)) tx_state_nxt = TX_STOP;
            TX_STOP: begin
               tx_state_nxt = TX_IDLE;
               tx_done      = 1'b1;
            end
            default:  tx_state_nxt = TX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) tx_state <= TX_IDLE;
      else        tx_state <= tx_state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_idx    <= '0;
         tx_shift  <= '0;
         tx_out    <= 1'b1;
         tx_empty  <= 1'b1;
         ld_tx_ack <= 1'b0;
      end else begin
         if (ld_tx_ack && !ld_tx_req) ld_tx_ack <= 1'b0;
         if (tx_load) begin
            tx_shift  <= tx_data;
            tx_empty  <= 1'b0;
            ld_tx_ack <= 1'b1;
         end
         if (tx_done) tx_empty <= 1'b1;
         // tx_out is registered from the bit about to be on the line; tx_shift drains LSB first.
         if (tx_tick) begin
            case (tx_state)
               TX_IDLE: if (tx_state_nxt == TX_START) tx_out <= 1'b0;
               TX_START: begin
                  tx_idx   <= '0;
                  tx_out   <= tx_shift[0];
                  tx_shift <= tx_shift >> 1;
               end
               TX_DATA: begin
                  if (tx_state_nxt == TX_STOP) begin
                     tx_out <= 1'b1;
                  end else begin
                     tx_idx   <= tx_idx + 3'd1;
                     tx_out   <= tx_shift[0];
                     tx_shift <= tx_shift >> 1;
                  end
               end
               default: tx_out <= 1'b1;
            endcase
         end
      end
   end

   logic       rx_s1, rx_s2;
   rx_state_t  rx_state, rx_state_nxt;
   logic [3:0] rx_cnt;
   logic [2:0] rx_idx;
   logic [7:0] rx_shift;
   logic       rx_hold;
   logic       rx_sample;
   logic       rx_good;
   logic       rx_bad;
   logic       uld_take;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= rx_in;
         rx_s2 <= rx_s1;
      end
   end

   always_comb begin
      rx_state_nxt = rx_state;
      rx_good      = 1'b0;
      rx_bad       = 1'b0;
      rx_sample    = rx_tick && (rx_cnt == 4'(OVERSAMPLE - 1));
      if (!rx_enable) begin
         rx_state_nxt = RX_IDLE;
      end else if (rx_tick) begin
         case (rx_state)
            RX_IDLE:  if (!rx_s2 && !rx_hold) rx_state_nxt = RX_START;
            RX_START: if (rx_cnt == 4'(MID_SAMPLE - 1)) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_sample && rx_idx == 3'(DATA_BITS - 1)) rx_state_nxt = RX_STOP;
            RX_STOP: begin
               if (rx_sample) begin
                  rx_state_nxt = RX_IDLE;
                  rx_good      = rx_s2;
                  rx_bad       = !rx_s2;
               end
            end
            default:  rx_state_nxt = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rx_state <= RX_IDLE;
      else        rx_state <= rx_state_nxt;
   end

   // rx_hold keeps a low line after a bad stop bit from being taken as a new start bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_cnt   <= '0;
         rx_idx   <= '0;
         rx_shift <= '0;
         rx_hold  <= 1'b0;
      end else if (!rx_enable) begin
         rx_cnt  <= '0;
         rx_idx  <= '0;
         rx_hold <= 1'b0;
      end else if (rx_tick) begin
         case (rx_state)
            RX_IDLE: begin
               rx_cnt <= '0;
               rx_idx <= '0;
               if (rx_s2) rx_hold <= 1'b0;
            end
            RX_START: rx_cnt <= (rx_cnt == 4'(MID_SAMPLE - 1)) ? 4'd0 : rx_cnt + 4'd1;
            RX_DATA: begin
               rx_cnt <= rx_cnt + 4'd1;
               if (rx_sample) begin
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  rx_idx   <= rx_idx + 3'd1;
               end
            end
            RX_STOP: begin
               rx_cnt <= rx_cnt + 4'd1;
               if (rx_bad) rx_hold <= 1'b1;
            end
            default: rx_cnt <= '0;
         endcase
      end
   end

   assign uld_take = uld_rx_req && !uld_rx_ack;

   // A frame completing on the unload edge wins: rx_empty ends at 0 with the new byte.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         uld_rx_ack <= 1'b0;
         rx_empty   <= 1'b1;
         rx_data    <= '0;
      end else begin
         if (uld_rx_ack && !uld_rx_req) uld_rx_ack <= 1'b0;
         if (uld_take) begin
            uld_rx_ack <= 1'b1;
            rx_empty   <= 1'b1;
         end
         if (rx_good) begin
            rx_data  <= rx_shift;
            rx_empty <= 1'b0;
         end
      end
   end

`ifdef UART_ERR_FLAGS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;
      end else begin
         if (uld_take) begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
         end
         if (rx_bad) rx_frame_err <= 1'b1;
         if (rx_good && !rx_empty) rx_overrun <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_dl11_serial_core.sv
// Self-checking bench for dl11_serial_core at 16 clocks per bit (CLK_HZ=160000, BAUD=10000).
`timescale 1ns/1ps
module tb_dl11_serial_core;

   localparam int CLK_HZ = 160000;
   localparam int BAUD   = 10000;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ld_tx_req = 1'b0;
   logic       ld_tx_ack;
   logic [7:0] tx_data = 8'h00;
   logic       tx_enable = 1'b1;
   logic       tx_out;
   logic       tx_empty;
   logic       uld_rx_req = 1'b0;
   logic       uld_rx_ack;
   logic [7:0] rx_data;
   logic       rx_enable = 1'b1;
   logic       rx_in = 1'b1;
   logic       rx_empty;
`ifdef UART_ERR_FLAGS_EN
   logic       rx_frame_err;
   logic       rx_overrun;
`endif

   int vectors = 0;
   int miscompares = 0;

   // Reference model of the receive-side register view.
   logic       exp_empty = 1'b1;
   logic [7:0] exp_data = 8'h00;
   logic       exp_fe = 1'b0;
   logic       exp_ov = 1'b0;

   always #5 clk = ~clk;

   dl11_serial_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
      .clk        (clk),
      .reset      (reset),
      .ld_tx_req  (ld_tx_req),
      .ld_tx_ack  (ld_tx_ack),
      .tx_data    (tx_data),
      .tx_enable  (tx_enable),
      .tx_out     (tx_out),
      .tx_empty   (tx_empty),
      .uld_rx_req (uld_rx_req),
      .uld_rx_ack (uld_rx_ack),
      .rx_data    (rx_data),
      .rx_enable  (rx_enable),
      .rx_in      (rx_in),
      .rx_empty   (rx_empty)
`ifdef UART_ERR_FLAGS_EN
      ,
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun)
`endif
   );

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // 8N1 line level of bit slot i (0 = start, 1..8 = data LSB first, 9 = stop).
   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i == 9) return 1'b1;
      return b[i-1];
   endfunction

   task automatic tx_load(input logic [7:0] b, input int hold);
      @(negedge clk);
      tx_data   = b;
      ld_tx_req = 1'b1;
      @(negedge clk);
      vectors++;
      if (ld_tx_ack !== 1'b1) begin miscompares++; $display("FAIL tx_ack_rise got %b want 1", ld_tx_ack); end
      vectors++;
      if (tx_empty !== 1'b0) begin miscompares++; $display("FAIL tx_empty_after_load got %b want 0", tx_empty); end
      repeat (hold) @(negedge clk);
      vectors++;
      if (ld_tx_ack !== 1'b1) begin miscompares++; $display("FAIL tx_ack_hold got %b want 1", ld_tx_ack); end
      ld_tx_req = 1'b0;
      @(negedge clk);
      vectors++;
      if (ld_tx_ack !== 1'b0) begin miscompares++; $display("FAIL tx_ack_fall got %b want 0", ld_tx_ack); end
   endtask

   task automatic tx_capture(input logic [7:0] b, input bit drop_en);
      int n = 0;
      while (tx_out !== 1'b0 && n < 64) begin @(negedge clk); n++; end
      vectors++;
      if (tx_out !== 1'b0) begin
         miscompares++; $display("FAIL tx_start_timeout byte %h got tx_out %b want 0", b, tx_out);
         return;
      end
      if (drop_en) tx_enable = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         vectors++;
         if (tx_out !== frame_bit(b, i)) begin
            miscompares++; $display("FAIL tx_bit byte %h slot %0d got %b want %b", b, i, tx_out, frame_bit(b, i));
         end
         if (i < 9) repeat (16) @(negedge clk);
      end
      vectors++;
      if (tx_empty !== 1'b0) begin miscompares++; $display("FAIL tx_empty_in_stop got %b want 0", tx_empty); end
      n = 0;
      while (tx_empty !== 1'b1 && n < 12) begin @(negedge clk); n++; end
      vectors++;
      if (tx_empty !== 1'b1) begin miscompares++; $display("FAIL tx_empty_after_stop got %b want 1", tx_empty); end
      tx_enable = 1'b1;
   endtask

   // Drives one frame on rx_in, updates the model, then compares the register view.
   task automatic rx_frame(input logic [7:0] b, input logic stop);
      @(negedge clk);
      rx_in = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         repeat (16) @(negedge clk);
      end
      rx_in = stop;
      repeat (16) @(negedge clk);
      rx_in = 1'b1;
      repeat (4) @(negedge clk);
      if (rx_enable) begin
         if (stop) begin
            if (!exp_empty) exp_ov = 1'b1;
            exp_data  = b;
            exp_empty = 1'b0;
         end else begin
            exp_fe = 1'b1;
         end
      end
      vectors++;
      if (rx_empty !== exp_empty) begin miscompares++; $display("FAIL rx_empty byte %h got %b want %b", b, rx_empty, exp_empty); end
      vectors++;
      if (rx_data !== exp_data) begin miscompares++; $display("FAIL rx_data byte %h got %h want %h", b, rx_data, exp_data); end
`ifdef UART_ERR_FLAGS_EN
      vectors++;
      if (rx_frame_err !== exp_fe) begin miscompares++; $display("FAIL rx_frame_err got %b want %b", rx_frame_err, exp_fe); end
      vectors++;
      if (rx_overrun !== exp_ov) begin miscompares++; $display("FAIL rx_overrun got %b want %b", rx_overrun, exp_ov); end
`endif
   endtask

   task automatic rx_unload();
      @(negedge clk);
      uld_rx_req = 1'b1;
      @(negedge clk);
      exp_empty = 1'b1;
      exp_fe    = 1'b0;
      exp_ov    = 1'b0;
      vectors++;
      if (uld_rx_ack !== 1'b1) begin miscompares++; $display("FAIL uld_ack_rise got %b want 1", uld_rx_ack); end
      vectors++;
      if (rx_empty !== 1'b1) begin miscompares++; $display("FAIL uld_rx_empty got %b want 1", rx_empty); end
      vectors++;
      if (rx_data !== exp_data) begin miscompares++; $display("FAIL uld_rx_data_kept got %h want %h", rx_data, exp_data); end
`ifdef UART_ERR_FLAGS_EN
      vectors++;
      if ({rx_frame_err, rx_overrun} !== 2'b00) begin
         miscompares++; $display("FAIL uld_flags_clear got %b%b want 00", rx_frame_err, rx_overrun);
      end
`endif
      uld_rx_req = 1'b0;
      @(negedge clk);
      vectors++;
      if (uld_rx_ack !== 1'b0) begin miscompares++; $display("FAIL uld_ack_fall got %b want 0", uld_rx_ack); end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      vectors++;
      if (tx_out !== 1'b1) begin miscompares++; $display("FAIL reset_tx_out got %b want 1", tx_out); end
      vectors++;
      if (tx_empty !== 1'b1) begin miscompares++; $display("FAIL reset_tx_empty got %b want 1", tx_empty); end
      vectors++;
      if (rx_empty !== 1'b1) begin miscompares++; $display("FAIL reset_rx_empty got %b want 1", rx_empty); end
      vectors++;
      if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
      vectors++;
      if ({ld_tx_ack, uld_rx_ack} !== 2'b00) begin
         miscompares++; $display("FAIL reset_acks got %b%b want 00", ld_tx_ack, uld_rx_ack);
      end
`ifdef UART_ERR_FLAGS_EN
      vectors++;
      if ({rx_frame_err, rx_overrun} !== 2'b00) begin
         miscompares++; $display("FAIL reset_flags got %b%b want 00", rx_frame_err, rx_overrun);
      end
`endif
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_tx();
      tx_load(8'h41, 0);
      tx_capture(8'h41, 1'b0);
   endtask

   task automatic test_tx_random();
      for (int k = 0; k < 4; k++) begin
         logic [7:0] b;
         b = 8'($urandom);
         tx_load(b, int'($urandom_range(0, 2)));
         tx_capture(b, 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_tx_enable();
      int lows = 0;
      tx_enable = 1'b0;
      tx_load(8'hC3, 0);
      repeat (48) begin
         @(negedge clk);
         if (tx_out !== 1'b1) lows++;
      end
      vectors++;
      if (lows != 0) begin miscompares++; $display("FAIL tx_enable_block got %0d low cycles want 0", lows); end
      vectors++;
      if (tx_empty !== 1'b0) begin miscompares++; $display("FAIL tx_enable_pending got %b want 0", tx_empty); end
      tx_enable = 1'b1;
      tx_capture(8'hC3, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ~a;
      tx_load(a, 0);
      fork
         begin
            tx_capture(a, 1'b0);
            tx_capture(b, 1'b0);
         end
         begin
            int n = 0;
            logic prev_empty = 1'b0;
            repeat (20) @(negedge clk);
            tx_data   = b;
            ld_tx_req = 1'b1;
            @(negedge clk);
            while (ld_tx_ack !== 1'b1 && n < 400) begin
               prev_empty = tx_empty;
               @(negedge clk);
               n++;
            end
            vectors++;
            if (ld_tx_ack !== 1'b1 || n < 100) begin
               miscompares++; $display("FAIL b2b_ack_delay got ack %b after %0d clks want 1 after >=100", ld_tx_ack, n);
            end
            vectors++;
            if (prev_empty !== 1'b1) begin miscompares++; $display("FAIL b2b_ack_when_empty got %b want 1", prev_empty); end
            n = 0;
            while (tx_empty !== 1'b1 && n < 400) begin @(negedge clk); n++; end
            repeat (20) @(negedge clk);
            vectors++;
            if (tx_empty !== 1'b1 || ld_tx_ack !== 1'b1) begin
               miscompares++; $display("FAIL b2b_single_load got empty %b ack %b want 1 1", tx_empty, ld_tx_ack);
            end
            ld_tx_req = 1'b0;
            @(negedge clk);
            vectors++;
            if (ld_tx_ack !== 1'b0) begin miscompares++; $display("FAIL b2b_ack_fall got %b want 0", ld_tx_ack); end
         end
      join
   endtask

   task automatic test_rx();
      rx_frame(8'h0D, 1'b1);
      rx_unload();
   endtask

   task automatic test_rx_frame_err();
      rx_frame(8'h55, 1'b0);
      rx_frame(8'($urandom), 1'b1);
      rx_unload();
   endtask

   task automatic test_rx_glitch_disable();
      @(negedge clk);
      rx_in = 1'b0;
      repeat (4) @(negedge clk);
      rx_in = 1'b1;
      repeat (200) @(negedge clk);
      vectors++;
      if (rx_empty !== 1'b1) begin miscompares++; $display("FAIL rx_glitch got rx_empty %b want 1", rx_empty); end
      rx_enable = 1'b0;
      rx_frame(8'hAA, 1'b1);
      rx_enable = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_rx_overrun_random();
      rx_frame(8'h3C, 1'b1);
      rx_frame(8'hE7, 1'b1);
      rx_unload();
      for (int k = 0; k < 5; k++) begin
         rx_frame(8'($urandom), 1'($urandom_range(0, 3) != 0));
         if ($urandom_range(0, 1) == 1) rx_unload();
      end
      rx_unload();
   endtask

   task automatic test_reset_midframe();
      int n = 0;
      tx_load(8'h5A, 0);
      while (tx_out !== 1'b0 && n < 64) begin @(negedge clk); n++; end
      repeat (40) @(negedge clk);
      reset = 1'b0;
      #1;
      vectors++;
      if (tx_out !== 1'b1 || tx_empty !== 1'b1) begin
         miscompares++; $display("FAIL reset_midframe got tx_out %b tx_empty %b want 1 1", tx_out, tx_empty);
      end
      exp_empty = 1'b1; exp_data = 8'h00; exp_fe = 1'b0; exp_ov = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      tx_load(8'h96, 0);
      tx_capture(8'h96, 1'b0);
      rx_frame(8'h81, 1'b1);
   endtask

   initial begin
      test_reset();
      test_tx();
      test_tx_random();
      test_tx_enable();
      test_back_to_back();
      test_rx();
      test_rx_frame_err();
      test_rx_glitch_disable();
      test_rx_overrun_random();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
